gmii_rx_framer: RTL and testbench

- GMII receive-side framer: turns the PCS/PMA GMII RX byte stream (rxd/rx_dv/rx_er at 125 MHz) into a byte-wide AXI-Stream frame interface for the MAC-side fabric.
- It is the counterpart of the GMII TX feed into the PCS/PMA core.
- Strips preamble/SFD, optionally strips FCS, checks CRC-32, length and rx_er, flags bad frames on tuser at tlast, and keeps good/bad frame counters.
- No backpressure: GMII cannot stall, so the downstream consumer must always accept.

---
 rtl/gmii_rx_framer.sv | 183 ++++++++++++++++++
 tb/tb_gmii_rx_framer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD, optionally the FCS, checks CRC-32, length and rx_er,
// and forwards frame bytes as a byte-wide AXI-Stream with a bad-frame flag on tuser at tlast.
`timescale 1ns / 1ps

module gmii_rx_framer #(
    parameter int unsigned STRIP_FCS = 1,
    parameter int unsigned MIN_FRAME = 64,
    parameter int unsigned MAX_FRAME = 1522
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [7:0]  gmii_rxd,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic        rx_active,
    output logic [31:0] frame_good_cnt,
    output logic [31:0] frame_bad_cnt
);

    localparam int unsigned DEPTH     = (STRIP_FCS != 0) ? 5 : 1;
    localparam logic [15:0] LEN_DEPTH = 16'(DEPTH);
    localparam logic [15:0] LEN_BEAT  = (STRIP_FCS != 0) ? 16'd6 : 16'd1;
    localparam logic [15:0] LEN_MIN   = 16'(MIN_FRAME);
    localparam logic [15:0] LEN_MAX   = 16'(MAX_FRAME);
    localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

    typedef enum logic [1:0] {StIdle, StPre, StData, StDrop} state_e;

    state_e      state_q, state_d;
    logic [7:0]  rxd_q;
    logic        dv_q, er_q;
    logic [7:0]  pipe_q [DEPTH];
    logic [7:0]  pipe_d [DEPTH];
    logic [31:0] crc_q, crc_d;
    logic [15:0] len_q, len_d;
    logic        err_q, err_d;
    logic [7:0]  tdata_d;
    logic        tvalid_d, tlast_d, tuser_d;
    logic [31:0] good_d, bad_d;

    logic pre_stay, pre_sfd, pre_bad, cut, frame_bad;

    // Reflected CRC-32 (poly 0x04C11DB7 as 0xEDB88320), LSB of each byte first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) c = (c >> 1) ^ 32'hEDB88320;
            else                c = c >> 1;
        end
        return c;
    endfunction

    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    assign pre_sfd   = dv_q && !er_q && (rxd_q == 8'hD5);
    assign pre_stay  = dv_q && !er_q && (rxd_q == 8'h55);
    assign pre_bad   = dv_q && !pre_sfd && !pre_stay;
    assign cut       = dv_q && (len_q == LEN_MAX);
    // The residue constant is in MSB-first form; the register is kept reflected.
    assign frame_bad = err_q || (bitrev32(crc_q) != CRC_RESIDUE) || (len_q < LEN_MIN);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state_q <= StIdle;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StPre: begin
                if (pre_sfd)       state_d = StData;
                else if (pre_stay) state_d = StPre;
                else if (pre_bad)  state_d = StDrop;
                else               state_d = StIdle;
            end
            StData: begin
                if (!dv_q)    state_d = StIdle;
                else if (cut) state_d = StDrop;
            end
            StDrop: begin
                if (!dv_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rx_active = (state_q != StIdle);
        pipe_d    = pipe_q;
        crc_d     = crc_q;
        len_d     = len_q;
        err_d     = err_q;
        tdata_d   = 8'h00;
        tvalid_d  = 1'b0;
        tlast_d   = 1'b0;
        tuser_d   = 1'b0;
        good_d    = frame_good_cnt;
        bad_d     = frame_bad_cnt;
        case (state_q)
            StIdle, StPre: begin
                if (pre_sfd) begin
                    len_d = 16'd0;
                    crc_d = 32'hFFFFFFFF;
                    err_d = 1'b0;
                end else if (pre_bad) begin
                    bad_d = frame_bad_cnt + 32'd1;
                end
            end
            StData: begin
                if (!dv_q) begin
                    if (len_q >= LEN_BEAT) begin
                        tvalid_d = 1'b1;
                        tlast_d  = 1'b1;
                        tuser_d  = frame_bad;
                        tdata_d  = pipe_q[DEPTH-1];
                    end
                    if ((len_q >= LEN_BEAT) && !frame_bad) good_d = frame_good_cnt + 32'd1;
                    else                                   bad_d  = frame_bad_cnt + 32'd1;
                end else if (cut) begin
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b1;
                    tuser_d  = 1'b1;
                    tdata_d  = pipe_q[DEPTH-1];
                    len_d    = LEN_MAX + 16'd1;
                    bad_d    = frame_bad_cnt + 32'd1;
                end else begin
                    crc_d     = crc32_byte(crc_q, rxd_q);
                    len_d     = len_q + 16'd1;
                    err_d     = err_q | er_q;
                    pipe_d[0] = rxd_q;
                    for (int unsigned i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
                    if (len_q >= LEN_DEPTH) begin
                        tvalid_d = 1'b1;
                        tdata_d  = pipe_q[DEPTH-1];
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rxd_q          <= 8'h00;
            dv_q           <= 1'b0;
            er_q           <= 1'b0;
            pipe_q         <= '{default: 8'h00};
            crc_q          <= 32'hFFFFFFFF;
            len_q          <= 16'd0;
            err_q          <= 1'b0;
            m_axis_tdata   <= 8'h00;
            m_axis_tvalid  <= 1'b0;
            m_axis_tlast   <= 1'b0;
            m_axis_tuser   <= 1'b0;
            frame_good_cnt <= 32'd0;
            frame_bad_cnt  <= 32'd0;
        end else begin
            rxd_q          <= gmii_rxd;
            dv_q           <= gmii_rx_dv;
            er_q           <= gmii_rx_er;
            pipe_q         <= pipe_d;
            crc_q          <= crc_d;
            len_q          <= len_d;
            err_q          <= err_d;
            m_axis_tdata   <= tdata_d;
            m_axis_tvalid  <= tvalid_d;
            m_axis_tlast   <= tlast_d;
            m_axis_tuser   <= tuser_d;
            frame_good_cnt <= good_d;
            frame_bad_cnt  <= bad_d;
        end
    end

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Bench for gmii_rx_framer: table-driven frames with hand-derived expectations, hand-written
// corner sequences and random frames checked against a frame-level reference model.
`timescale 1ns / 1ps

module tb_gmii_rx_framer;

    localparam int MAXF = 1522;
    localparam int MINF = 64;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [7:0]  gmii_rxd = 8'h00;
    logic        gmii_rx_dv = 1'b0;
    logic        gmii_rx_er = 1'b0;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid, m_axis_tlast, m_axis_tuser, rx_active;
    logic [31:0] frame_good_cnt, frame_bad_cnt;

    gmii_rx_framer #(.STRIP_FCS(1), .MIN_FRAME(MINF), .MAX_FRAME(MAXF)) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .gmii_rxd       (gmii_rxd),
        .gmii_rx_dv     (gmii_rx_dv),
        .gmii_rx_er     (gmii_rx_er),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tuser   (m_axis_tuser),
        .rx_active      (rx_active),
        .frame_good_cnt (frame_good_cnt),
        .frame_bad_cnt  (frame_bad_cnt)
    );

    always #4 aclk = ~aclk;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
    } beat_t;

    typedef struct {
        int pay;
        bit fcs;
        bit corrupt;
        int er_pos;
        int beats;
        bit user;
        int good_inc;
        int bad_inc;
    } vec_t;

    beat_t      got_q[$];
    beat_t      exp_q[$];
    int         got_cyc[$];
    logic [7:0] fb[$];
    vec_t       vecs[12];
    int         er_pos = -1;
    int         cyc = 0;
    int         first_cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         exp_good = 0;
    int         exp_bad = 0;

    always @(posedge aclk) cyc <= cyc + 1;

    always @(negedge aclk) begin
        if (aresetn && m_axis_tvalid) begin
            got_q.push_back({m_axis_tdata, m_axis_tlast, m_axis_tuser});
            got_cyc.push_back(cyc);
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // Textbook CRC-32 (MSB-first register, reflected in/out, final inversion) over fb[0..n-1].
    function automatic logic [31:0] crc32_ref(input int n);
        logic [31:0] c;
        logic [31:0] r;
        logic [7:0]  b;
        c = 32'hFFFFFFFF;
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < 8; j++) b[j] = fb[k][7-j];
            c = c ^ {b, 24'h000000};
            for (int j = 0; j < 8; j++) c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
        end
        for (int j = 0; j < 32; j++) r[j] = c[31-j];
        return ~r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic check_beats(input string name);
        int bad_i;
        bad_i = -1;
        check({name, " beat count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            if (bad_i < 0 && (got_q[i].data !== exp_q[i].data || got_q[i].last !== exp_q[i].last
                || (exp_q[i].last && got_q[i].user !== exp_q[i].user))) bad_i = i;
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            if (bad_i >= 0) begin
                n_bad++;
                $display("FAIL %s beat %0d: got data=%02h last=%b user=%b, expected data=%02h last=%b user=%b",
                         name, bad_i, got_q[bad_i].data, got_q[bad_i].last, got_q[bad_i].user,
                         exp_q[bad_i].data, exp_q[bad_i].last, exp_q[bad_i].user);
            end
        end
        got_q.delete();
        exp_q.delete();
        got_cyc.delete();
    endtask

    task automatic check_counters(input string name);
        check({name, " good_cnt"}, frame_good_cnt, exp_good);
        check({name, " bad_cnt"}, frame_bad_cnt, exp_bad);
    endtask

    task automatic drive(input logic [7:0] d, input logic dv, input logic er);
        @(negedge aclk);
        gmii_rxd   = d;
        gmii_rx_dv = dv;
        gmii_rx_er = er;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(8'h00, 1'b0, 1'b0);
    endtask

    task automatic build_frame(input int pay, input bit with_fcs, input bit corrupt, input bit rnd);
        logic [31:0] fcs;
        logic [7:0]  d;
        fb.delete();
        for (int i = 0; i < pay; i++) begin
            d = rnd ? 8'($urandom_range(0, 255)) : i[7:0];
            fb.push_back(d);
        end
        if (with_fcs) begin
            fcs = crc32_ref(pay);
            if (corrupt) fcs[0] = ~fcs[0];
            fb.push_back(fcs[7:0]);
            fb.push_back(fcs[15:8]);
            fb.push_back(fcs[23:16]);
            fb.push_back(fcs[31:24]);
        end
    endtask

    task automatic send_frame(input int gap);
        for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0);
        drive(8'hD5, 1'b1, 1'b0);
        foreach (fb[i]) begin
            drive(fb[i], 1'b1, (i == er_pos));
            if (i == 0) first_cyc = cyc;
        end
        idle(gap);
    endtask

    // Frame-level expectation: everything but the FCS is forwarded; oversize frames are cut
    // when byte MAXF+1 arrives, by which time all but the five newest bytes have gone out.
    task automatic model_frame();
        int          n;
        int          fwd;
        logic        bad;
        logic [31:0] fcs_rx;
        n = fb.size();
        if (n > MAXF) begin
            fwd = MAXF + 1 - 5;
            bad = 1'b1;
        end else if (n <= 5) begin
            fwd = 0;
            bad = 1'b1;
        end else begin
            fcs_rx = {fb[n-1], fb[n-2], fb[n-3], fb[n-4]};
            bad = (er_pos >= 0 && er_pos < n) || (crc32_ref(n - 4) != fcs_rx) || (n < MINF);
            fwd = n - 4;
        end
        for (int i = 0; i < fwd; i++) exp_q.push_back({fb[i], (i == fwd - 1), (i == fwd - 1) && bad});
        if (bad) exp_bad++;
        else     exp_good++;
    endtask

    initial begin
        int pay, r;
        bit corrupt;

        //           pay   fcs corr er   beats user good bad
        vecs[0]  = '{60,   1,  0,   -1,  60,   0,   1,   0};
        vecs[1]  = '{60,   1,  1,   -1,  60,   1,   0,   1};
        vecs[2]  = '{96,   1,  0,   10,  96,   1,   0,   1};
        vecs[3]  = '{1596, 1,  0,   -1,  1518, 1,   0,   1};
        vecs[4]  = '{36,   1,  0,   -1,  36,   1,   0,   1};
        vecs[5]  = '{3,    0,  0,   -1,  0,    0,   0,   1};
        vecs[6]  = '{59,   1,  0,   -1,  59,   1,   0,   1};
        vecs[7]  = '{1518, 1,  0,   -1,  1518, 0,   1,   0};
        vecs[8]  = '{1519, 1,  0,   -1,  1518, 1,   0,   1};
        vecs[9]  = '{2,    1,  0,   -1,  2,    1,   0,   1};
        vecs[10] = '{1,    1,  0,   -1,  0,    0,   0,   1};
        vecs[11] = '{0,    1,  0,   -1,  0,    0,   0,   1};

        repeat (3) @(negedge aclk);
        #1;
        check("reset tvalid", m_axis_tvalid, 1'b0);
        check("reset tlast/tuser/tdata", {m_axis_tlast, m_axis_tuser, m_axis_tdata}, 10'd0);
        check("reset rx_active", rx_active, 1'b0);
        check_counters("reset");
        @(negedge aclk);
        aresetn = 1'b1;
        idle(3);

        for (int v = 0; v < 12; v++) begin
            build_frame(vecs[v].pay, vecs[v].fcs, vecs[v].corrupt, 1'b0);
            er_pos = vecs[v].er_pos;
            for (int i = 0; i < vecs[v].beats; i++)
                exp_q.push_back({i[7:0], (i == vecs[v].beats - 1),
                                 (i == vecs[v].beats - 1) && vecs[v].user});
            exp_good += vecs[v].good_inc;
            exp_bad  += vecs[v].bad_inc;
            send_frame(1);
            idle(6);
            if (v == 0 && got_cyc.size() > 0) check("first beat latency", got_cyc[0] - first_cyc, 7);
            check_beats($sformatf("vec%0d", v));
            check_counters($sformatf("vec%0d", v));
        end
        er_pos = -1;

        // Bad preamble, then a good frame after a single idle cycle.
        drive(8'h55, 1'b1, 1'b0);
        drive(8'h55, 1'b1, 1'b0);
        drive(8'h5D, 1'b1, 1'b0);
        drive(8'h00, 1'b1, 1'b0);
        drive(8'h00, 1'b1, 1'b0);
        drive(8'h00, 1'b1, 1'b0);
        check("rx_active in drop", rx_active, 1'b1);
        idle(1);
        exp_bad++;
        build_frame(60, 1'b1, 1'b0, 1'b1);
        model_frame();
        send_frame(1);
        idle(6);
        check_beats("bad preamble then good");
        check_counters("bad preamble then good");

        // Back-to-back frames separated by one dv-low cycle.
        build_frame(70, 1'b1, 1'b0, 1'b1);
        model_frame();
        send_frame(1);
        build_frame(50, 1'b1, 1'b1, 1'b1);
        model_frame();
        send_frame(1);
        idle(6);
        check_beats("back to back");
        check_counters("back to back");

        for (int f = 0; f < 16; f++) begin
            r = $urandom_range(0, 9);
            pay = (r == 0) ? $urandom_range(1505, 1530) : $urandom_range(0, 90);
            corrupt = ($urandom_range(0, 3) == 0);
            build_frame(pay, 1'b1, corrupt, 1'b1);
            er_pos = ($urandom_range(0, 4) == 0) ? $urandom_range(0, pay + 3) : -1;
            model_frame();
            send_frame($urandom_range(1, 3));
        end
        er_pos = -1;
        idle(6);
        check_beats("random");
        check_counters("random");

        // Reset in the middle of a frame; the rest of that frame falls to DROP.
        for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0);
        drive(8'hD5, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) drive(8'h20, 1'b1, 1'b0);
        @(negedge aclk);
        aresetn = 1'b0;
        gmii_rxd = 8'h21;
        #1;
        check("mid reset tvalid", m_axis_tvalid, 1'b0);
        check("mid reset rx_active", rx_active, 1'b0);
        exp_good = 0;
        exp_bad = 0;
        check_counters("mid reset");
        drive(8'h22, 1'b1, 1'b0);
        drive(8'h23, 1'b1, 1'b0);
        @(negedge aclk);
        aresetn = 1'b1;
        got_q.delete();
        got_cyc.delete();
        for (int i = 0; i < 4; i++) drive(8'h24, 1'b1, 1'b0);
        idle(6);
        exp_bad = 1;
        check_beats("after mid reset");
        check_counters("after mid reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
